ram_burst_reader: RTL and testbench

//   Read-side master for the 4096 x 64 dual-port RAM: on a start command it

---
 rtl/ram_burst_reader.sv | 177 +++++++++++++++++
 tb/tb_ram_burst_reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// Burst read master: issues sequential reads to a dual-port RAM and streams the
// returned words through a small first-word-fall-through FIFO to a valid/ready consumer.
module ram_burst_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64,
    parameter int FIFO_D = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   burst_len,
    output logic              busy,
    output logic              done,
    output logic              read_enb,
    output logic [ADDR_W-1:0] rd_address,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
);

    localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CW = $clog2(FIFO_D) + 1;
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    // Handshake: a word moves to the consumer in every cycle where m_valid && m_ready.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_issued;
    logic [ADDR_W:0]     r_accepted;
    logic [RD_LAT-1:0]   r_pipe;
    logic [DATA_W-1:0]   r_mem [FIFO_D];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_zero_done;

    logic                w_accept;
    logic                w_rd;
    logic                w_push;
    logic                w_pop;
    logic                w_last;
    logic                w_done;
    logic                w_credit_ok;
    logic [CW-1:0]       w_inflight;

    assign w_accept = start && (r_state == S_IDLE);
    assign w_push   = r_pipe[RD_LAT-1];
    assign w_pop    = (r_count != '0) && m_ready;
    assign w_last   = (r_accepted == (r_len - LEN_ONE));

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_pipe[i]);
        end
    end

    // Words already buffered plus words still in the RAM pipe must fit in the FIFO.
    assign w_credit_ok = ({1'b0, r_count} + {1'b0, w_inflight}) < (CW+1)'(FIFO_D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_done = r_zero_done;
                if (w_accept && (burst_len != '0)) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                w_rd = (r_issued < r_len) && w_credit_ok;
                if (w_rd && (r_issued == (r_len - LEN_ONE))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && w_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base      <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_accepted  <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_accept && (burst_len == '0);
            if (w_accept) begin
                r_base     <= base_addr;
                r_len      <= burst_len;
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (w_rd) begin
                    r_issued <= r_issued + LEN_ONE;
                end
                if (w_pop) begin
                    r_accepted <= r_accepted + LEN_ONE;
                end
            end
        end
    end

    // Valid tag travels alongside each outstanding read so its data is captured on arrival.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_D; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_out;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = w_done;
    assign read_enb   = w_rd;
    assign rd_address = r_base + r_issued[ADDR_W-1:0];
    assign m_valid    = (r_count != '0);
    assign m_data     = r_mem[r_rd_ptr];
    assign m_last     = m_valid && w_last;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: RAM model, vector table of bursts,
// address/data scoreboards and hand sequences for reset, zero length and aborts.
module tb_ram_burst_reader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;
    localparam int FIFO_D = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   burst_len;
    logic              busy;
    logic              done;
    logic              read_enb;
    logic [ADDR_W-1:0] rd_address;
    logic [DATA_W-1:0] data_out = '0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    ram_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_D(FIFO_D), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .burst_len(burst_len),
        .busy(busy), .done(done), .read_enb(read_enb), .rd_address(rd_address),
        .data_out(data_out), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return {16'hC0DE, 4'h0, a, 16'h5A5A, 4'h0, ~a};
    endfunction

    logic [DATA_W-1:0] ram [4096];
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = pat(ADDR_W'(i));
    end
    always @(posedge clk) begin
        if (read_enb) data_out <= ram[rd_address];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int                cyc = 0;
    int                n_reads = 0;
    int                n_acc = 0;
    int                n_done = 0;
    int                first_rd = 0;
    int                last_rd = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              hold_chk = 1'b0;
    logic [DATA_W-1:0] held_d = '0;
    logic              held_l = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hold_chk = 1'b0;
        end else begin
            if (read_enb) begin
                n_reads++;
                if (n_reads == 1) first_rd = cyc;
                last_rd   = cyc;
                last_addr = rd_address;
                if (addr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_read: got addr %0h expected no read", rd_address);
                end else begin
                    chk("rd_address", rd_address, addr_q.pop_front());
                end
            end
            if (hold_chk) begin
                chk("hold_data", m_data, held_d);
                chk("hold_last", m_last, held_l);
            end
            if (m_valid && m_ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_word: got %0h expected none", m_data);
                end else begin
                    chk("m_last", m_last, exp_q.size() == 1);
                    chk("m_data", m_data, exp_q.pop_front());
                end
            end
            hold_chk = m_valid && !m_ready;
            held_d   = m_data;
            held_l   = m_last;
            if (done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_read_enb"}, read_enb, 0);
        chk({tag, "_rd_address"}, rd_address, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
    endtask

    task automatic load_expect(input logic [ADDR_W-1:0] base, input int len);
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < len; i++) begin
            addr_q.push_back(base + ADDR_W'(i));
            exp_q.push_back(pat(base + ADDR_W'(i)));
        end
        n_reads = 0;
        n_acc   = 0;
    endtask

    task automatic run_burst(input logic [ADDR_W-1:0] base, input int len, input int stall,
                             input bit poke, input logic [ADDR_W-1:0] exp_last);
        int d0;
        bit got;
        load_expect(base, len);
        d0 = n_done;
        tick();
        start = 1'b1; base_addr = base; burst_len = (ADDR_W+1)'(len); m_ready = (stall == 0);
        tick();
        start = 1'b0; base_addr = 12'h555; burst_len = 13'd7;
        chk("busy_after_accept", busy, 1);
        if (poke) begin
            tick();
            start = 1'b1; base_addr = 12'h7A0; burst_len = 13'd3;
            tick();
            start = 1'b0;
        end
        if (stall > 0) begin
            repeat (stall) tick();
            chk("stall_reads", n_reads, (len < FIFO_D) ? len : FIFO_D);
            chk("stall_no_accept", n_acc, 0);
            m_ready = 1'b1;
        end
        got = 1'b0;
        for (int c = 0; c < len + 100; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", got, 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("words_left", exp_q.size(), 0);
        chk("addrs_left", addr_q.size(), 0);
        chk("read_count", n_reads, len);
        chk("done_count", n_done - d0, 1);
        chk("last_addr", last_addr, exp_last);
        if (stall == 0) chk("reads_back_to_back", last_rd - first_rd, len - 1);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                len;
        int                stall;
        bit                poke;
        logic [ADDR_W-1:0] last_addr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d0;
        bit reached;
        vecs[0] = '{base: 12'h010, len: 8,    stall: 0,  poke: 1'b0, last_addr: 12'h017};
        vecs[1] = '{base: 12'hFFE, len: 4,    stall: 0,  poke: 1'b0, last_addr: 12'h001};
        vecs[2] = '{base: 12'h400, len: 16,   stall: 20, poke: 1'b0, last_addr: 12'h40F};
        vecs[3] = '{base: 12'h300, len: 6,    stall: 0,  poke: 1'b1, last_addr: 12'h305};
        vecs[4] = '{base: 12'hFFF, len: 1,    stall: 0,  poke: 1'b0, last_addr: 12'hFFF};
        vecs[5] = '{base: 12'h123, len: 4096, stall: 0,  poke: 1'b0, last_addr: 12'h122};

        rst = 1'b1; start = 1'b0; base_addr = '0; burst_len = '0; m_ready = 1'b0;
        repeat (2) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].base, vecs[v].len, vecs[v].stall, vecs[v].poke, vecs[v].last_addr);
        end

        // zero-length burst completes immediately without touching the RAM
        load_expect(12'h050, 0);
        d0 = n_done;
        tick();
        start = 1'b1; base_addr = 12'h050; burst_len = '0;
        tick();
        start = 1'b0;
        chk("zero_len_done", done, 1);
        chk("zero_len_busy", busy, 0);
        tick();
        chk("zero_len_done_drop", done, 0);
        chk("zero_len_busy_next", busy, 0);
        chk("zero_len_reads", n_reads, 0);
        chk("zero_len_done_count", n_done - d0, 1);

        // abort a running burst with reset part-way through the cycle
        load_expect(12'h200, 10);
        d0 = n_done;
        m_ready = 1'b1;
        tick();
        start = 1'b1; base_addr = 12'h200; burst_len = 13'd10;
        tick();
        start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            #1;
            if (n_acc >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        chk("abort_reached_3", reached, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        repeat (2) tick();
        exp_q.delete();
        addr_q.delete();
        rst = 1'b0;
        repeat (3) tick();
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_idle_read_enb", read_enb, 0);
        chk("abort_idle_m_valid", m_valid, 0);

        run_burst(12'h100, 2, 0, 1'b0, 12'h101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

endmodule
